// File: rtl/temp_calc_pkg.sv
// Shared FSM state type, default widths and a small helper for temp_calc_seq.
package temp_calc_pkg;

   localparam int REF_W_DEF  = 8;
   localparam int ADC_W_DEF  = 16;
   localparam int OUT_W_DEF  = 32;
   localparam int SHIFT_DEF  = 6;
   localparam int NUM_CH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      SQUARE,
      MULT,
      ACC,
      OUT
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Iterative unsigned A x B multiplier, one bit of B per cycle.
// done is high during the cycle whose edge performs the final step; prod is valid after that edge.
module shift_add_mult #(
   parameter int A_W   = 31,
   parameter int B_W   = 15,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   input  logic [CNT_W-1:0] steps,
   output logic [A_W-1:0]   prod,
   output logic             done
);

   logic [A_W-1:0]   acc;
   logic [A_W-1:0]   a_sh;
   logic [B_W-1:0]   b_sh;
   logic [CNT_W-1:0] left;
   logic [A_W-1:0]   cur_a;
   logic [A_W-1:0]   cur_acc;
   logic [B_W-1:0]   cur_b;
   logic [CNT_W-1:0] rem;
   logic             active;

   // The start cycle already performs the first step straight from the operand inputs.
   always_comb begin
      cur_a   = start ? a : a_sh;
      cur_b   = start ? b : b_sh;
      cur_acc = start ? '0 : acc;
      rem     = start ? steps : left;
      active  = start || (left != '0);
      done    = active && (rem == CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         a_sh <= '0;
         b_sh <= '0;
         left <= '0;
      end else if (active) begin
         acc  <= cur_acc + (cur_b[0] ? cur_a : '0);
         a_sh <= cur_a << 1;
         b_sh <= cur_b >> 1;
         left <= rem - CNT_W'(1);
      end
   end

   assign prod = acc;

endmodule

// File: rtl/temp_calc_seq.sv
// Multi-channel temperature calculator: out = base[ch] +/- ((ref^2 * |adc|) >> SHIFT).
// Optional signed saturation of the final add/sub is enabled by defining TEMP_CALC_SAT_EN.
module temp_calc_seq
   import temp_calc_pkg::*;
#(
   parameter int REF_W  = REF_W_DEF,
   parameter int ADC_W  = ADC_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int SHIFT  = SHIFT_DEF,
   parameter int NUM_CH = NUM_CH_DEF,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             base_wr_en,
   input  logic [CH_W-1:0]  base_wr_ch,
   input  logic [OUT_W-1:0] base_wr_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CH_W-1:0]  in_ch,
   input  logic [REF_W-1:0] in_ref,
   input  logic [ADC_W-1:0] in_adc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CH_W-1:0]  out_ch,
   output logic [OUT_W-1:0] out_data,
   output state_t           fsm_state
);

   localparam int P_W   = 2 * REF_W + ADC_W - 1;
   localparam int B_W   = max_int(REF_W, ADC_W - 1);
   localparam int CNT_W = $clog2(B_W + 1);
   localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

   state_t           state;
   logic [OUT_W-1:0] base [NUM_CH];
   logic [OUT_W-1:0] base_sel;
   logic [CH_W-1:0]  ch_r;
   logic [REF_W-1:0] ref_r;
   logic [ADC_W-2:0] mag_r;
   logic             sign_r;
   logic [OUT_W-1:0] base_r;
   logic             first_r;
   logic             mul_start;
   logic             mul_done;
   logic [P_W-1:0]   mul_a;
   logic [B_W-1:0]   mul_b;
   logic [CNT_W-1:0] mul_steps;
   logic [P_W-1:0]   prod;
   logic [P_W-1:0]   shifted;
   logic [OUT_W-1:0] scaled;
   logic [OUT_W-1:0] res;

   assign fsm_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) base[i] <= '0;
      end else if (base_wr_en && ({1'b0, base_wr_ch} < NUM_CH_L)) begin
         base[base_wr_ch] <= base_wr_data;
      end
   end

   // Out-of-range channels still compute, against a zero base.
   assign base_sel = ({1'b0, in_ch} < NUM_CH_L) ? base[in_ch] : '0;

   // One multiplier serves both passes: ref*ref first, then sq*mag with sq fed back.
   always_comb begin
      mul_start = first_r && ((state == SQUARE) || (state == MULT));
      if (state == SQUARE) begin
         mul_a     = P_W'(ref_r);
         mul_b     = B_W'(ref_r);
         mul_steps = CNT_W'(REF_W);
      end else begin
         mul_a     = prod;
         mul_b     = B_W'(mag_r);
         mul_steps = CNT_W'(ADC_W - 1);
      end
   end

   shift_add_mult #(
      .A_W   (P_W),
      .B_W   (B_W),
      .CNT_W (CNT_W)
   ) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .a     (mul_a),
      .b     (mul_b),
      .steps (mul_steps),
      .prod  (prod),
      .done  (mul_done)
   );

   assign shifted = prod >> SHIFT;
   assign scaled  = OUT_W'(shifted);

`ifdef TEMP_CALC_SAT_EN
   localparam logic signed [OUT_W+1:0] S_MAX = $signed({3'b000, {(OUT_W-1){1'b1}}});
   localparam logic signed [OUT_W+1:0] S_MIN = $signed({3'b111, {(OUT_W-1){1'b0}}});
   logic signed [OUT_W+1:0] wide;

   // Two guard bits make the signed add/sub exact before clamping.
   always_comb begin
      if (sign_r) wide = $signed({{2{base_r[OUT_W-1]}}, base_r}) - $signed({2'b00, scaled});
      else        wide = $signed({{2{base_r[OUT_W-1]}}, base_r}) + $signed({2'b00, scaled});
      if (wide > S_MAX)      res = {1'b0, {(OUT_W-1){1'b1}}};
      else if (wide < S_MIN) res = {1'b1, {(OUT_W-1){1'b0}}};
      else                   res = wide[OUT_W-1:0];
   end
`else
   assign res = sign_r ? (base_r - scaled) : (base_r + scaled);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ch_r      <= '0;
         ref_r     <= '0;
         mag_r     <= '0;
         sign_r    <= 1'b0;
         base_r    <= '0;
         first_r   <= 1'b0;
      end else begin
         first_r <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ch_r     <= in_ch;
                  ref_r    <= in_ref;
                  mag_r    <= in_adc[ADC_W-2:0];
                  sign_r   <= in_adc[ADC_W-1];
                  base_r   <= base_sel;
                  in_ready <= 1'b0;
                  first_r  <= 1'b1;
                  state    <= SQUARE;
               end
            end
            SQUARE: begin
               if (mul_done) begin
                  first_r <= 1'b1;
                  state   <= MULT;
               end
            end
            MULT: begin
               if (mul_done) state <= ACC;
            end
            ACC: begin
               out_data  <= res;
               out_ch    <= ch_r;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
